// File: rtl/quan_param_loader.sv
// Loads per-group bias, scale and shift words from a narrow stream into the
// quantization parameter RAMs, packing BEATS stream beats per RAM word.
module quan_param_loader #(
  parameter int CHANNEL_OUT_NUM       = 8,
  parameter int WIDTH_DATA_ADD        = 32,
  parameter int WIDTH_AXI             = 64,
  parameter int WIDTH_CHANNEL_NUM_REG = 10,
  parameter int WIDTH_BIAS_RAM_ADDRA  = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      Start,
  input  logic [WIDTH_CHANNEL_NUM_REG-1:0]          Channel_Out_Num_REG,
  input  logic [WIDTH_AXI-1:0]                      S_Data,
  input  logic                                      S_Valid,
  output logic                                      S_Ready,
  output logic [CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0] wr_data,
  output logic [WIDTH_BIAS_RAM_ADDRA-1:0]           wr_addr,
  output logic                                      wr_en_bias,
  output logic                                      wr_en_scale,
  output logic                                      wr_en_shift,
  output logic                                      Busy,
  output logic                                      Done,
  output logic [2:0]                                dbg_state
);

  localparam int WORD_W = CHANNEL_OUT_NUM * WIDTH_DATA_ADD;
  localparam int BEATS  = WORD_W / WIDTH_AXI;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [WIDTH_CHANNEL_NUM_REG-1:0] ONE_G = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_SCALE = 3'd2,
    S_SHIFT = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                           state_q;
  logic [WIDTH_CHANNEL_NUM_REG-1:0] n_q;
  logic [WIDTH_CHANNEL_NUM_REG-1:0] g_q;
  logic [BW-1:0]                    beat_q;
  logic [WORD_W-1:0]                buf_q;
  logic [WORD_W-1:0]                word_d;
  logic [WORD_W-1:0]                wr_data_q;
  logic [WIDTH_BIAS_RAM_ADDRA-1:0]  wr_addr_q;
  logic                             en_bias_q, en_scale_q, en_shift_q;
  logic                             busy_q, done_q;

  // Assembly buffer with the incoming beat merged into its lane slot.
  always_comb begin
    word_d = buf_q;
    word_d[int'(beat_q)*WIDTH_AXI +: WIDTH_AXI] = S_Data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      g_q        <= '0;
      beat_q     <= '0;
      buf_q      <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      en_bias_q  <= 1'b0;
      en_scale_q <= 1'b0;
      en_shift_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      en_bias_q  <= 1'b0;
      en_scale_q <= 1'b0;
      en_shift_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            n_q    <= Channel_Out_Num_REG;
            g_q    <= '0;
            beat_q <= '0;
            busy_q <= 1'b1;
            if (Channel_Out_Num_REG == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_BIAS;
            end
          end
        end
        S_BIAS, S_SCALE, S_SHIFT: begin
          if (S_Valid) begin
            buf_q <= word_d;
            if (beat_q == LAST_BEAT) begin
              beat_q    <= '0;
              wr_data_q <= word_d;
              wr_addr_q <= WIDTH_BIAS_RAM_ADDRA'(g_q);
              case (state_q)
                S_BIAS: begin
                  en_bias_q <= 1'b1;
                  state_q   <= S_SCALE;
                end
                S_SCALE: begin
                  en_scale_q <= 1'b1;
                  state_q    <= S_SHIFT;
                end
                default: begin
                  en_shift_q <= 1'b1;
                  // Full-width compare: the address alone may wrap.
                  if (g_q == n_q - ONE_G) begin
                    state_q <= S_FLUSH;
                  end else begin
                    g_q     <= g_q + ONE_G;
                    state_q <= S_BIAS;
                  end
                end
              endcase
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign S_Ready     = (state_q == S_BIAS) || (state_q == S_SCALE) || (state_q == S_SHIFT);
  assign wr_data     = wr_data_q;
  assign wr_addr     = wr_addr_q;
  assign wr_en_bias  = en_bias_q;
  assign wr_en_scale = en_scale_q;
  assign wr_en_shift = en_shift_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_quan_param_loader.sv
// Bench for quan_param_loader: a driver streams beats and queues the RAM
// writes the stream implies; a negedge monitor pops and compares each strobe.
module tb_quan_param_loader;

  localparam int CH    = 8;
  localparam int WDA   = 32;
  localparam int WA    = 64;
  localparam int WC    = 10;
  localparam int WAD   = 8;
  localparam int WORD  = CH * WDA;
  localparam int BEATS = WORD / WA;
  localparam int EW    = 2 + WAD + WORD;

  logic            clk = 1'b0;
  logic            rst;
  logic            Start;
  logic [WC-1:0]   Channel_Out_Num_REG;
  logic [WA-1:0]   S_Data;
  logic            S_Valid;
  logic            S_Ready;
  logic [WORD-1:0] wr_data;
  logic [WAD-1:0]  wr_addr;
  logic            wr_en_bias, wr_en_scale, wr_en_shift;
  logic            Busy, Done;
  logic [2:0]      dbg_state;

  quan_param_loader dut (
    .clk                 (clk),
    .rst                 (rst),
    .Start               (Start),
    .Channel_Out_Num_REG (Channel_Out_Num_REG),
    .S_Data              (S_Data),
    .S_Valid             (S_Valid),
    .S_Ready             (S_Ready),
    .wr_data             (wr_data),
    .wr_addr             (wr_addr),
    .wr_en_bias          (wr_en_bias),
    .wr_en_scale         (wr_en_scale),
    .wr_en_shift         (wr_en_shift),
    .Busy                (Busy),
    .Done                (Done),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;
  int sent_cnt = 0;
  int done_cnt = 0;
  int last_shift_cyc = -10;
  bit chk_done_lat = 1'b1;
  bit prev_done = 1'b0;

  task automatic check(input string name, input bit ok,
                       input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every RAM write and the completion timing.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [1:0]    typ;
    if (S_Valid && S_Ready) acc_cnt++;
    if (wr_en_bias || wr_en_scale || wr_en_shift) begin
      typ = wr_en_scale ? 2'd1 : (wr_en_shift ? 2'd2 : 2'd0);
      check("strobe_onehot", (32'(wr_en_bias) + 32'(wr_en_scale) + 32'(wr_en_shift)) == 1,
            EW'({wr_en_bias, wr_en_scale, wr_en_shift}), EW'(1));
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1'b0, {typ, wr_addr, wr_data}, '0);
      end else begin
        e = exp_q.pop_front();
        check("write_word", {typ, wr_addr, wr_data} == e, {typ, wr_addr, wr_data}, e);
      end
      if (wr_en_shift) last_shift_cyc = cyc;
    end
    if (Done) begin
      done_cnt++;
      check("done_busy", Busy == 1'b1, EW'(Busy), EW'(1));
      if (chk_done_lat)
        check("done_latency", cyc == last_shift_cyc + 1, EW'(cyc - last_shift_cyc), EW'(1));
    end
    if (prev_done) check("busy_after_done", Busy == 1'b0, EW'(Busy), EW'(0));
    prev_done = Done;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [WC-1:0] n);
    Start = 1'b1;
    Channel_Out_Num_REG = n;
    @(posedge clk); #1;
    Start = 1'b0;
    Channel_Out_Num_REG = WC'($urandom);
  endtask

  task automatic send_beat(input logic [WA-1:0] d, input int gap);
    bit rdy;
    int budget;
    repeat (gap) begin
      S_Valid = 1'b0;
      @(posedge clk); #1;
    end
    S_Valid = 1'b1;
    S_Data  = d;
    budget  = 0;
    do begin
      @(negedge clk);
      rdy = S_Ready;
      @(posedge clk); #1;
      budget++;
    end while (!rdy && budget < 200);
    if (rdy) sent_cnt++;
    else check("beat_timeout", 1'b0, '0, EW'(1));
  endtask

  // mode: 0 = sequential data 1,2,3.., 1 = random data.
  // gap_mode: 0 = continuous, 1 = toggling, 2 = random gaps.
  // mid_start: beat index at which an ignored Start is pulsed (-1 none).
  // abort_at: beat index before which streaming stops (-1 none).
  task automatic stream(input int n, input int mode, input int gap_mode,
                        input int mid_start, input int abort_at);
    logic [WORD-1:0] acc;
    logic [WA-1:0]   d;
    int total, g, t, k, gap;
    total = n * 3 * BEATS;
    acc = '0;
    for (int i = 0; i < total; i++) begin
      if (i == abort_at) break;
      g = i / (3 * BEATS);
      t = (i / BEATS) % 3;
      k = i % BEATS;
      d = (mode == 0) ? WA'(i + 1) : {$urandom, $urandom};
      acc[k*WA +: WA] = d;
      if (k == BEATS - 1) exp_q.push_back({t[1:0], g[WAD-1:0], acc});
      gap = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
      if (i == mid_start) begin
        Start = 1'b1;
        Channel_Out_Num_REG = 10'd5;
      end
      send_beat(d, gap);
      Start = 1'b0;
    end
    S_Valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (c < budget) begin
      @(negedge clk);
      if (Done) break;
      c++;
    end
    if (c >= budget) check("done_timeout", 1'b0, '0, EW'(1));
    @(posedge clk); #1;
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    check(name, !S_Ready && !Busy, EW'({S_Ready, Busy}), '0);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0, seen_ready, seen_wr, wait_c;
    rst = 1'b1; Start = 1'b0; Channel_Out_Num_REG = '0;
    S_Data = '0; S_Valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_outputs", {S_Ready, wr_en_bias, wr_en_scale, wr_en_shift, Busy, Done} == 6'b0,
          EW'({S_Ready, wr_en_bias, wr_en_scale, wr_en_shift, Busy, Done}), '0);
    check("reset_data", wr_data == '0 && wr_addr == '0, EW'({wr_addr, wr_data}), '0);
    @(posedge clk); #1;

    // N=1, continuous, beats 1..12
    do_start(10'd1);
    stream(1, 0, 0, -1, -1);
    wait_done(20);
    check("beats_n1", acc_cnt == 12, EW'(acc_cnt), EW'(12));

    // N=3, toggling valid
    d0 = done_cnt;
    do_start(10'd3);
    stream(3, 1, 1, -1, -1);
    wait_done(20);
    check("done_once_n3", done_cnt == d0 + 1, EW'(done_cnt - d0), EW'(1));

    // N=0: no stream, Done follows quickly, no writes
    chk_done_lat = 1'b0;
    d0 = done_cnt; seen_ready = 0; seen_wr = 0; wait_c = 0;
    do_start(10'd0);
    while (wait_c < 6) begin
      @(negedge clk);
      if (S_Ready) seen_ready++;
      if (wr_en_bias || wr_en_scale || wr_en_shift) seen_wr++;
      wait_c++;
    end
    @(posedge clk); #1;
    check("n0_no_ready", seen_ready == 0, EW'(seen_ready), '0);
    check("n0_no_write", seen_wr == 0, EW'(seen_wr), '0);
    check("n0_done", done_cnt == d0 + 1, EW'(done_cnt - d0), EW'(1));
    chk_done_lat = 1'b1;

    // N=2 with an ignored Start during group 0 scale
    d0 = acc_cnt;
    do_start(10'd2);
    stream(2, 1, 0, BEATS + 1, -1);
    wait_done(20);
    check("mid_start_beats", acc_cnt - d0 == 24, EW'(acc_cnt - d0), EW'(24));
    expect_idle("mid_start_idle");
    expect_idle("mid_start_idle2");

    // Reset after 2 beats of group 1 scale, with Start asserted alongside
    do_start(10'd2);
    stream(2, 1, 2, -1, 3 * BEATS + BEATS + 2);
    rst = 1'b1; Start = 1'b1; Channel_Out_Num_REG = 10'd1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_outputs",
          {S_Ready, wr_en_bias, wr_en_scale, wr_en_shift, Busy, Done} == 6'b0 &&
          wr_data == '0 && wr_addr == '0,
          {wr_en_bias, wr_en_scale, wr_en_shift, wr_addr, wr_data}, '0);
    @(posedge clk); #1;
    rst = 1'b0; Start = 1'b0;
    expect_idle("rst_start_ignored");
    check("rst_queue_empty", exp_q.size() == 0, EW'(exp_q.size()), '0);

    // Fresh N=1 load, then back-to-back loads with random N and gaps
    do_start(10'd1);
    stream(1, 1, 0, -1, -1);
    wait_done(20);
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 4);
      d0 = acc_cnt;
      do_start(WC'(n));
      stream(n, 1, 2, -1, -1);
      wait_done(20);
      check("b2b_beats", acc_cnt - d0 == n * 3 * BEATS, EW'(acc_cnt - d0), EW'(n * 3 * BEATS));
    end

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size() == 0, EW'(exp_q.size()), '0);
    check("beats_total", acc_cnt == sent_cnt, EW'(acc_cnt), EW'(sent_cnt));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $fatal(1);
  end

endmodule
